// File: rtl/otp_seq_pkg.sv
// otp_seq_pkg
// Shared types and default timing for the OTP read sequencer.
//   state_e      : sequencer states
//   T_SETUP      : default CSB/address setup cycles before the strobe
//   T_STROBE     : default strobe-high cycles
//   T_HOLD       : default cycles after the strobe falls before the response
//   max3()       : helper used to size the phase timer
package otp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    localparam int unsigned T_SETUP  = 2;
    localparam int unsigned T_STROBE = 4;
    localparam int unsigned T_HOLD   = 1;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/otp_seq_timer.sv
// otp_seq_timer
// Loadable down-counter timing the SETUP/STROBE/HOLD phases.
//   clk_i      : block clock
//   rst_i      : synchronous active-high reset, clears the count
//   load_i     : load load_val_i on this edge (takes priority over counting)
//   load_val_i : phase length minus one
//   zero_o     : count has reached zero (last cycle of the current phase)
module otp_seq_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/otp_read_seq.sv
// otp_read_seq
// Read-only OTP macro sequencer: accepts a burst read request, walks the
// addresses through SETUP/STROBE/HOLD on the OTP pins and returns one word
// per address over a valid/ready response channel.
//   xtal_clk, por_rst           : clock, synchronous active-high reset
//   req_valid/req_ready         : request handshake (ready only in IDLE)
//   req_addr, req_len           : start address, burst length minus one
//   rsp_valid/rsp_ready         : response handshake
//   rsp_data, rsp_addr, rsp_last: returned word, its address, end of burst
//   req_err                     : one-cycle pulse on a rejected request
//   busy                        : sequencer not in IDLE
//   o_otp_*, i_otp_q            : OTP macro pins (read path only)
//
// state  | meaning
// IDLE   | waiting for a request, CSB high
// SETUP  | CSB low, address driven, waiting before the strobe
// STROBE | read strobe high, data captured on the last cycle
// HOLD   | strobe low, address held before presenting the word
// RESP   | word presented until the consumer takes it
module otp_read_seq #(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 8,
    parameter int unsigned LW       = 4,
    parameter int unsigned T_SETUP  = otp_seq_pkg::T_SETUP,
    parameter int unsigned T_STROBE = otp_seq_pkg::T_STROBE,
    parameter int unsigned T_HOLD   = otp_seq_pkg::T_HOLD
) (
    input  logic          xtal_clk,
    input  logic          por_rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_addr,
    output logic          rsp_last,
    output logic          req_err,
    output logic          busy,
    output logic          o_otp_csb,
    output logic          o_otp_strobe,
    output logic          o_otp_load,
    output logic          o_otp_pgenb,
    output logic          o_otp_vddqsw,
    output logic [AW-1:0] o_otp_addr,
    input  logic [DW-1:0] i_otp_q
);

    import otp_seq_pkg::*;

    localparam int unsigned T_MAX = max3(T_SETUP, T_STROBE, T_HOLD);
    localparam int unsigned CW    = $clog2(T_MAX + 1);
    // Padding to compute the burst end address one bit wider than AW.
    localparam int unsigned PAD   = AW + 1 - LW;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          last_q, last_d;
    logic          err_q, err_d;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    logic [AW:0]   end_addr;
    logic          overflow;

    // A burst that would run past the top address is rejected, never wrapped.
    assign end_addr = {1'b0, req_addr} + {{PAD{1'b0}}, req_len};
    assign overflow = end_addr[AW];

    otp_seq_timer #(
        .W (CW)
    ) u_timer (
        .clk_i      (xtal_clk),
        .rst_i      (por_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        raddr_d  = raddr_q;
        last_d   = last_q;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (overflow) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = ST_SETUP;
                        addr_d   = req_addr;
                        cnt_d    = req_len;
                        tmr_load = 1'b1;
                        tmr_val  = CW'(T_SETUP - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(T_STROBE - 1);
                end
            end
            ST_STROBE: begin
                if (tmr_zero) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(T_HOLD - 1);
                    data_d   = i_otp_q;
                    raddr_d  = addr_q;
                    last_d   = (cnt_q == '0);
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    state_d  = ST_RESP;
                    tmr_load = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    tmr_load = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SETUP;
                        addr_d  = addr_q + AW'(1);
                        cnt_d   = cnt_q - LW'(1);
                        tmr_val = CW'(T_SETUP - 1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge xtal_clk) begin
        if (por_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            raddr_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            raddr_q <= raddr_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign req_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_data     = data_q;
    assign rsp_addr     = raddr_q;
    assign rsp_last     = last_q;
    assign req_err      = err_q;

    // CSB and LOAD follow busy so CSB stays low across a whole burst.
    assign o_otp_csb    = ~busy;
    assign o_otp_load   = busy;
    assign o_otp_strobe = (state_q == ST_STROBE);
    assign o_otp_pgenb  = 1'b1;
    assign o_otp_vddqsw = 1'b0;
    assign o_otp_addr   = busy ? addr_q : '0;

endmodule

// File: tb/tb_otp_read_seq.sv
module tb_otp_read_seq;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        logic        last;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance
    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [9:0]  a_req_addr, a_rsp_addr, a_otp_addr;
    logic [3:0]  a_req_len;
    logic [7:0]  a_rsp_data, a_q;
    logic        a_rsp_last, a_req_err, a_busy;
    logic        a_csb, a_strobe, a_load, a_pgenb, a_vddqsw;

    // wide instance, short strobe
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [11:0] b_req_addr, b_rsp_addr, b_otp_addr;
    logic [3:0]  b_req_len;
    logic [15:0] b_rsp_data, b_q;
    logic        b_rsp_last, b_req_err, b_busy;
    logic        b_csb, b_strobe, b_load, b_pgenb, b_vddqsw;

    int n_checks = 0;
    int n_errors = 0;
    int strobe_a = 0;
    int csb_gap_a = 0;
    int csb_low_a = 0;
    int strobe_b = 0;
    sb_t qa[$];
    sb_t qb[$];

    function automatic logic [7:0] otp_a(input logic [9:0] ad);
        return ad[7:0] ^ 8'hA0;
    endfunction

    function automatic logic [15:0] otp_b(input logic [11:0] ad);
        return {ad, 4'h3} ^ 16'h5A5A;
    endfunction

    // OTP macro models: data only valid while the strobe is high
    assign a_q = a_strobe ? otp_a(a_otp_addr) : 8'h00;
    assign b_q = b_strobe ? otp_b(b_otp_addr) : 16'h0000;

    otp_read_seq dut_a (
        .xtal_clk(clk), .por_rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(a_req_addr), .req_len(a_req_len),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_data(a_rsp_data), .rsp_addr(a_rsp_addr), .rsp_last(a_rsp_last),
        .req_err(a_req_err), .busy(a_busy),
        .o_otp_csb(a_csb), .o_otp_strobe(a_strobe), .o_otp_load(a_load),
        .o_otp_pgenb(a_pgenb), .o_otp_vddqsw(a_vddqsw),
        .o_otp_addr(a_otp_addr), .i_otp_q(a_q)
    );

    otp_read_seq #(.AW(12), .DW(16), .LW(4), .T_SETUP(2), .T_STROBE(1), .T_HOLD(1)) dut_b (
        .xtal_clk(clk), .por_rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .req_len(b_req_len),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data), .rsp_addr(b_rsp_addr), .rsp_last(b_rsp_last),
        .req_err(b_req_err), .busy(b_busy),
        .o_otp_csb(b_csb), .o_otp_strobe(b_strobe), .o_otp_load(b_load),
        .o_otp_pgenb(b_pgenb), .o_otp_vddqsw(b_vddqsw),
        .o_otp_addr(b_otp_addr), .i_otp_q(b_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // response monitors / scoreboards
    always @(negedge clk) begin
        sb_t e;
        if (a_strobe) strobe_a++;
        if (!a_csb) csb_low_a++;
        if (qa.size() != 0 && a_csb) csb_gap_a++;
        if (!rst) begin
            check("a_pgenb", a_pgenb, 1);
            check("a_vddqsw", a_vddqsw, 0);
            check("a_csb_vs_busy", a_csb, !a_busy);
            check("a_load_vs_busy", a_load, a_busy);
        end
        if (a_rsp_valid && a_rsp_ready) begin
            if (qa.size() == 0) begin
                check("a_sb_underflow", qa.size(), 1);
            end else begin
                e = qa.pop_front();
                check("a_rsp_data", a_rsp_data, e.data);
                check("a_rsp_addr", a_rsp_addr, e.addr);
                check("a_rsp_last", a_rsp_last, e.last);
            end
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (b_strobe) strobe_b++;
        if (!rst) check("b_csb_vs_busy", b_csb, !b_busy);
        if (b_rsp_valid && b_rsp_ready) begin
            if (qb.size() == 0) begin
                check("b_sb_underflow", qb.size(), 1);
            end else begin
                e = qb.pop_front();
                check("b_rsp_data", b_rsp_data, e.data);
                check("b_rsp_addr", b_rsp_addr, e.addr);
                check("b_rsp_last", b_rsp_last, e.last);
            end
        end
    end

    task automatic check_reset_a();
        check("rst_csb", a_csb, 1);
        check("rst_strobe", a_strobe, 0);
        check("rst_load", a_load, 0);
        check("rst_pgenb", a_pgenb, 1);
        check("rst_vddqsw", a_vddqsw, 0);
        check("rst_otp_addr", a_otp_addr, 0);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_rsp_data", a_rsp_data, 0);
        check("rst_rsp_addr", a_rsp_addr, 0);
        check("rst_rsp_last", a_rsp_last, 0);
        check("rst_req_err", a_req_err, 0);
        check("rst_busy", a_busy, 0);
    endtask

    // Issue a request, push the expected words, measure first-word latency.
    task automatic send_a(input logic [9:0] ad, input logic [3:0] ln, input int lat_exp);
        int k;
        @(negedge clk);
        k = 0;
        while (!a_req_ready && k < 200) begin @(negedge clk); k++; end
        check("a_req_ready", a_req_ready, 1);
        a_req_valid = 1'b1; a_req_addr = ad; a_req_len = ln;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        for (int i = 0; i <= int'(ln); i++)
            qa.push_back('{addr: 12'(ad + 10'(i)), data: 16'(otp_a(ad + 10'(i))), last: (i == int'(ln))});
        k = 0;
        while (!a_rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("a_latency", k, lat_exp);
    endtask

    task automatic wait_idle_a();
        int k;
        k = 0;
        while ((a_busy || qa.size() != 0) && k < 500) begin @(negedge clk); k++; end
        check("a_burst_done", qa.size(), 0);
    endtask

    task automatic send_b(input logic [11:0] ad, input logic [3:0] ln, input int lat_exp);
        int k;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_addr = ad; b_req_len = ln;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        for (int i = 0; i <= int'(ln); i++)
            qb.push_back('{addr: ad + 12'(i), data: otp_b(ad + 12'(i)), last: (i == int'(ln))});
        k = 0;
        while (!b_rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("b_latency", k, lat_exp);
        k = 0;
        while ((b_busy || qb.size() != 0) && k < 500) begin @(negedge clk); k++; end
        check("b_burst_done", qb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d0;
        logic [9:0] ad0;
        int k;
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_addr = '0; a_req_len = '0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_addr = '0; b_req_len = '0; b_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_a();
        check("a_rst_ready", a_req_ready, 1);
        check("b_rst_busy", b_busy, 0);
        check("b_rst_rsp_data", b_rsp_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single read
        strobe_a = 0;
        send_a(10'h005, 4'd0, 7);
        wait_idle_a();
        check("single_strobe_cycles", strobe_a, 4);

        // burst of 4
        strobe_a = 0; csb_gap_a = 0;
        send_a(10'h010, 4'd3, 7);
        wait_idle_a();
        check("burst_strobe_cycles", strobe_a, 16);
        check("burst_csb_gap", csb_gap_a, 0);
        @(negedge clk);
        check("burst_end_csb", a_csb, 1);
        check("burst_end_load", a_load, 0);

        // backpressure
        a_rsp_ready = 1'b0;
        send_a(10'h020, 4'd1, 7);
        d0 = a_rsp_data; ad0 = a_rsp_addr;
        strobe_a = 0;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid", a_rsp_valid, 1);
            check("bp_data", a_rsp_data, d0);
            check("bp_addr", a_rsp_addr, ad0);
        end
        check("bp_no_strobe", strobe_a, 0);
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (!a_rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("bp_next_latency", k, 7);
        wait_idle_a();

        // top-of-array boundary
        send_a(10'h3FE, 4'd1, 7);
        wait_idle_a();
        send_a(10'h3FF, 4'd0, 7);
        wait_idle_a();
        csb_low_a = 0;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_addr = 10'h3FF; a_req_len = 4'd1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check("err_pulse", a_req_err, 1);
        check("err_busy", a_busy, 0);
        @(posedge clk); #1;
        check("err_width", a_req_err, 0);
        repeat (5) @(posedge clk);
        #1;
        check("err_csb_never_low", csb_low_a, 0);

        // reset in the middle of a strobe
        @(negedge clk);
        a_req_valid = 1'b1; a_req_addr = 10'h030; a_req_len = 4'd3;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        k = 0;
        while (!a_strobe && k < 20) begin @(posedge clk); #1; k++; end
        check("setup_cycles", k, 2);
        @(posedge clk); #1;
        check("mid_strobe", a_strobe, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_a();
        strobe_a = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_strobe", strobe_a, 0);
        rst = 1'b0;
        strobe_a = 0;
        send_a(10'h044, 4'd0, 7);
        wait_idle_a();
        check("post_rst_strobe_cycles", strobe_a, 4);

        // wide instance, T_STROBE = 1
        strobe_b = 0;
        send_b(12'hABC, 4'd0, 4);
        check("b_strobe_cycles", strobe_b, 1);
        send_b(12'hFFE, 4'd1, 4);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_addr = 12'hFFF; b_req_len = 4'd1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        check("b_err_pulse", b_req_err, 1);
        check("b_err_csb", b_csb, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
